ioctl_sender: RTL
=================

IOCTL_SENDER -- requirements
Module: ioctl_sender

Interface
REQ-001 SHALL have parameter WR_GAP, default 3, idle cycles after each ioctl_wr pulse.
REQ-002 SHALL have parameter SETUP, default 2, cycles ioctl_download is high before the first write.
REQ-003 SHALL have parameter HOLD, default 2, cycles ioctl_download stays high after the last write.
REQ-004 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to begin a transfer; sampled only in IDLE.
REQ-007 index  in  8  image index (0=BIOS, nonzero=cart), latched on an accepted start.
REQ-008 length  in  25  byte count, latched on an accepted start.
REQ-009 src_data  in  8  next image byte.
REQ-010 src_valid  in  1  src_data valid.
REQ-011 src_ready  out  1  byte accepted when src_valid and src_ready are both high.
REQ-012 ioctl_wait  in  1  core stall request.
REQ-013 ioctl_download  out  1  transfer-active frame.
REQ-014 ioctl_index  out  8  latched index.
REQ-015 ioctl_addr  out  25  byte address of the current write.
REQ-016 ioctl_dout  out  8  write data.
REQ-017 ioctl_wr  out  1  single-cycle write strobe.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at normal completion.

Function
REQ-020 States SHALL be IDLE, SETUP, FETCH, WRITE, GAP, HOLD.
REQ-021 IDLE with start and length≠0: on the next edge SHALL latch index and length, set ioctl_download=1 and ioctl_addr=0, and enter SETUP.
REQ-022 IDLE with start and length=0: SHALL pulse done on the next cycle, keep ioctl_download low, and stay in IDLE.
REQ-023 SETUP SHALL last exactly SETUP cycles, then enter FETCH.
REQ-024 FETCH: src_ready SHALL equal ~ioctl_wait; on handshake SHALL register src_data into ioctl_dout and enter WRITE.
REQ-025 WRITE: ioctl_wr=1 for exactly one cycle; ioctl_addr and ioctl_dout SHALL be stable for that cycle.
REQ-026 After WRITE: SHALL enter HOLD if the byte was byte length-1; otherwise SHALL enter GAP, or FETCH directly when WR_GAP=0.
REQ-027 GAP SHALL last WR_GAP cycles, counting only cycles with ioctl_wait low.
REQ-028 ioctl_addr SHALL increment by 1 on the edge that leaves WRITE for a non-last byte; addresses SHALL be contiguous from 0 to length-1 with no wrap.
REQ-029 HOLD SHALL last HOLD cycles with ioctl_download high; on exit, ioctl_download=0 and done=1 SHALL appear in the same cycle, and the block SHALL return to IDLE.
REQ-030 ioctl_index SHALL stay constant from the accepted start until the next accepted start, including across the falling edge of ioctl_download.
REQ-031 start while busy SHALL be ignored.
REQ-032 src_ready SHALL be 0 outside FETCH.
REQ-033 ioctl_wr SHALL be 0 outside WRITE.
REQ-034 ioctl_wait SHALL never truncate or extend an ioctl_wr pulse already in progress.

Reset
REQ-035 reset SHALL force IDLE and drive ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, src_ready, busy and done to 0.
REQ-036 Reset mid-transfer SHALL drop ioctl_download on the next edge with no done pulse; the next transfer SHALL restart at address 0.

Structure
REQ-037 Shared package ioctl_pkg SHALL hold the state enum, IOCTL_ADDR_W=25, and index constants IDX_BIOS=8'd0 and IDX_CART=8'd1.
REQ-038 The block SHALL be a single module with no sub-module; it contains a remaining-byte counter and one shared SETUP/GAP/HOLD cycle counter.

Verification
REQ-039 index=1, length=4, bytes 41 42 43 44 always valid, defaults -> wr at addr 0..3 with matching dout, wr pulses 4 cycles apart, download high 2 cycles before the first wr and 2 cycles after the last, done coincides with download falling.
REQ-040 start with length=0 -> done one cycle later, download never high, no wr.
REQ-041 src_valid held low 10 cycles in FETCH -> no wr, download stays high, addr unchanged, then normal resume.
REQ-042 ioctl_wait high 5 cycles during FETCH and GAP -> src_ready low throughout, gap extended by 5 cycles, addresses contiguous.
REQ-043 reset asserted one cycle after the 2nd wr -> next cycle download=0, wr=0, addr=0, busy=0, no done; a following start with length=2 writes addr 0 and 1.
REQ-044 index=0, length=4096, start re-pulsed mid-transfer -> the re-pulse is ignored, last wr at addr 0xFFF, index stays 0 after download falls.

Source files
------------

// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared state encoding, address width and image index constants for the ioctl sender
package ioctl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FETCH, S_WRITE, S_GAP, S_HOLD} state_t;
    localparam int IOCTL_ADDR_W = 25;
    localparam int CNT_W = 16;
    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_CART = 8'd1;
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
    endfunction
endpackage

// File: rtl/ioctl_sender.sv
// ioctl_sender: streams a byte image into a core over the ioctl download port
// with setup, inter-write gap and hold framing around single-cycle write strobes.
module ioctl_sender
    import ioctl_pkg::*;
#(
    parameter int WR_GAP = 3,
    parameter int SETUP  = 2,
    parameter int HOLD   = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              index,
    input  logic [IOCTL_ADDR_W-1:0] length,
    input  logic [7:0]              src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic                    ioctl_wait,
    output logic                    ioctl_download,
    output logic [7:0]              ioctl_index,
    output logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    output logic [7:0]              ioctl_dout,
    output logic                    ioctl_wr,
    output logic                    busy,
    output logic                    done
);
    // The FETCH handshake cycle is the final setup/gap cycle, so those states cover the rest.
    localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(WR_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(HOLD);
    state_t                  r_state, w_state_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic [IOCTL_ADDR_W-1:0] r_rem, r_addr;
    logic [7:0]              r_dout, r_index;
    logic                    r_download, r_done, w_finish;
    logic                    w_accept, w_empty, w_hs, w_last;
    assign w_accept = (r_state == S_IDLE) && start && (length != '0);
    assign w_empty  = (r_state == S_IDLE) && start && (length == '0);
    assign w_hs     = (r_state == S_FETCH) && src_valid && !ioctl_wait;
    assign w_last   = r_rem == IOCTL_ADDR_W'(1);
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nx = w_accept ? ((SETUP > 1) ? S_SETUP : S_FETCH) : S_IDLE;
                w_cnt_nx   = SETUP_LD;
            end
            S_SETUP: begin
                w_state_nx = (r_cnt == '0) ? S_FETCH : S_SETUP;
                w_cnt_nx   = r_cnt - 1'b1;
            end
            S_FETCH: w_state_nx = w_hs ? S_WRITE : S_FETCH;
            S_WRITE: begin
                w_state_nx = w_last ? ((HOLD > 0) ? S_HOLD : S_IDLE) : ((WR_GAP > 1) ? S_GAP : S_FETCH);
                w_cnt_nx   = w_last ? HOLD_LD : GAP_LD;
                w_finish   = w_last && (HOLD == 0);
            end
            S_GAP: begin
                w_state_nx = (!ioctl_wait && r_cnt == '0) ? S_FETCH : S_GAP;
                w_cnt_nx   = ioctl_wait ? r_cnt : r_cnt - 1'b1;
            end
            S_HOLD: begin
                w_state_nx = (r_cnt == '0) ? S_IDLE : S_HOLD;
                w_cnt_nx   = r_cnt - 1'b1;
                w_finish   = r_cnt == '0;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_index    <= '0;
            r_download <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_empty || w_finish;
            if (w_accept) begin
                r_index    <= index;
                r_rem      <= length;
                r_addr     <= '0;
                r_download <= 1'b1;
            end
            if (w_finish) r_download <= 1'b0;
            if (w_hs) r_dout <= src_data;
            if (r_state == S_WRITE) begin
                r_rem <= r_rem - 1'b1;
                if (!w_last) r_addr <= r_addr + 1'b1;
            end
        end
    end
    assign src_ready      = (r_state == S_FETCH) && !ioctl_wait;
    assign ioctl_wr       = r_state == S_WRITE;
    assign busy           = r_state != S_IDLE;
    assign done           = r_done;
    assign ioctl_download = r_download;
    assign ioctl_index    = r_index;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
endmodule
